// File: rtl/spi_cnn_pkg.sv
// Shared command codes, frame lengths and FSM state encoding for the SPI CNN initiator.
package spi_cnn_pkg;

  localparam logic [1:0] CMD_LOAD_IMAGE   = 2'b00;
  localparam logic [1:0] CMD_LOAD_WEIGHTS = 2'b01;
  localparam logic [1:0] CMD_START_CNN    = 2'b10;
  localparam logic [1:0] CMD_READ_RESULT  = 2'b11;

  localparam int unsigned START_CLKS = 3;
  localparam int unsigned READ_CLKS  = 7;
  localparam int unsigned RESULT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SCLK_HIGH,
    ST_SCLK_LOW,
    ST_FETCH,
    ST_CS_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_sclk_timer.sv
// Loadable half-period down-counter; expire strobes once, CLK_DIV cycles after load.
module spi_sclk_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned W = $clog2(CLK_DIV + 1);

  logic [W-1:0] count_q, count_d;
  logic         run_q, run_d;

  always_comb begin
    count_d = count_q;
    run_d   = run_q;
    if (load) begin
      count_d = W'(CLK_DIV - 1);
      run_d   = 1'b1;
    end else if (run_q) begin
      if (count_q == '0) run_d = 1'b0;
      else               count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign expire = run_q && (count_q == '0);

endmodule

// File: rtl/spi_cnn_master.sv
// SPI mode-0 initiator framing CNN accelerator commands; optional abort via SPI_CNN_MASTER_ABORT_EN.
module spi_cnn_master
  import spi_cnn_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned N_ROWS        = 8,
  parameter int unsigned N_WEIGHTS     = 8,
  parameter int unsigned CS_GAP        = 2
) (
  input  logic                     i_CLOCK,
  input  logic                     i_RESET,
  input  logic                     i_start,
  input  logic [1:0]               i_cmd,
  input  logic [DATAWIDTH_BUS-1:0] i_tx_data,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  output logic                     o_SPI_Clk,
  output logic                     o_SPI_CS_n,
  output logic                     o_SPI_MOSI,
  input  logic                     i_SPI_MISO,
`ifdef SPI_CNN_MASTER_ABORT_EN
  input  logic                     i_abort,
  output logic                     o_aborted,
`endif
  output logic                     o_busy,
  output logic [RESULT_W-1:0]      o_result,
  output logic                     o_result_valid,
  output logic                     o_done
);

  localparam int unsigned MAXN = (N_ROWS > N_WEIGHTS) ? N_ROWS : N_WEIGHTS;
  localparam int unsigned EW   = $clog2(2 + DATAWIDTH_BUS * MAXN + 1);
  localparam int unsigned BW   = $clog2(DATAWIDTH_BUS);
  localparam int unsigned GW   = $clog2(CS_GAP + 1);

  state_e                     state_q, state_d;
  logic [1:0]                 cmd_q, cmd_d;
  logic [DATAWIDTH_BUS-1:0]   shift_q, shift_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [EW-1:0]              edge_q, edge_d;
  logic [RESULT_W-1:0]        res_sh_q, res_sh_d, result_q, result_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d, busy_q, busy_d;
  logic ready_q, ready_d, rv_q, rv_d, done_q, done_d;
  logic [EW-1:0]              total;
  logic                       tmr_load, tmr_expire, abort_now;

  spi_sclk_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk    (i_CLOCK),
    .rst    (i_RESET),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

`ifdef SPI_CNN_MASTER_ABORT_EN
  logic abort_q, abort_d, aborted_q, aborted_d;
  assign abort_now = abort_q | i_abort;
  assign abort_d   = (state_q inside {ST_CS_SETUP, ST_SCLK_HIGH, ST_SCLK_LOW, ST_FETCH}) ? abort_now :
                     (state_q == ST_CS_HOLD) ? abort_q : 1'b0;
  assign aborted_d = (state_q == ST_CS_HOLD) && tmr_expire && abort_q;
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      abort_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      abort_q   <= abort_d;
      aborted_q <= aborted_d;
    end
  end
  assign o_aborted = aborted_q;
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    case (cmd_q)
      CMD_LOAD_IMAGE:   total = EW'(2 + DATAWIDTH_BUS * N_ROWS);
      CMD_LOAD_WEIGHTS: total = EW'(2 + DATAWIDTH_BUS * N_WEIGHTS);
      CMD_START_CNN:    total = EW'(START_CLKS);
      default:          total = EW'(READ_CLKS);
    endcase
  end

  always_comb begin
    state_d   = state_q;   cmd_d    = cmd_q;    shift_d  = shift_q;
    bit_cnt_d = bit_cnt_q; edge_d   = edge_q;   res_sh_d = res_sh_q;
    result_d  = result_q;  gap_d    = gap_q;    sclk_d   = sclk_q;
    cs_n_d    = cs_n_q;    mosi_d   = mosi_q;   busy_d   = busy_q;
    ready_d   = ready_q;   rv_d     = 1'b0;     done_d   = 1'b0;
    tmr_load  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d   = ST_CS_SETUP;
        cmd_d     = i_cmd;
        cs_n_d    = 1'b0;
        busy_d    = 1'b1;
        mosi_d    = i_cmd[1];
        edge_d    = '0;
        bit_cnt_d = '0;
        shift_d   = '0;
        res_sh_d  = '0;
        tmr_load  = 1'b1;
      end
      ST_CS_SETUP, ST_SCLK_LOW: begin
        if (abort_now) begin
          state_d  = ST_CS_HOLD;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          state_d  = ST_SCLK_HIGH;
          sclk_d   = 1'b1;
          edge_d   = edge_q + EW'(1);
          tmr_load = 1'b1;
          // edge_q is the count before this rise, so 3..6 selects rising edges 4..7
          if (cmd_q == CMD_READ_RESULT && edge_q >= EW'(READ_CLKS - RESULT_W) && edge_q < EW'(READ_CLKS))
            res_sh_d = {res_sh_q[RESULT_W-2:0], i_SPI_MISO};
        end
      end
      ST_SCLK_HIGH: begin
        if (abort_now) begin
          state_d  = ST_SCLK_LOW;
          sclk_d   = 1'b0;
          tmr_load = 1'b1;
        end else if (tmr_expire) begin
          sclk_d = 1'b0;
          if (edge_q == total) begin
            state_d  = ST_CS_HOLD;
            tmr_load = 1'b1;
            if (cmd_q == CMD_READ_RESULT) begin
              result_d = res_sh_q;
              rv_d     = 1'b1;
            end
          end else if (!cmd_q[1] && edge_q != EW'(1) && bit_cnt_q == '0) begin
            state_d = ST_FETCH;
            ready_d = 1'b1;
          end else begin
            state_d  = ST_SCLK_LOW;
            tmr_load = 1'b1;
            if (edge_q == EW'(1)) begin
              mosi_d = cmd_q[0];
            end else begin
              mosi_d  = shift_q[DATAWIDTH_BUS-1];
              shift_d = shift_q << 1;
              if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - BW'(1);
            end
          end
        end
      end
      ST_FETCH: begin
        if (abort_now) begin
          state_d  = ST_CS_HOLD;
          ready_d  = 1'b0;
          tmr_load = 1'b1;
        end else if (i_tx_valid) begin
          state_d   = ST_SCLK_LOW;
          ready_d   = 1'b0;
          mosi_d    = i_tx_data[DATAWIDTH_BUS-1];
          shift_d   = {i_tx_data[DATAWIDTH_BUS-2:0], 1'b0};
          bit_cnt_d = BW'(DATAWIDTH_BUS - 1);
          tmr_load  = 1'b1;
        end
      end
      ST_CS_HOLD: if (tmr_expire) begin
        state_d = ST_GAP;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
        done_d  = 1'b1;
        gap_d   = GW'(CS_GAP - 1);
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q <= ST_IDLE;  cmd_q    <= '0;  shift_q  <= '0;  bit_cnt_q <= '0;
      edge_q  <= '0;       res_sh_q <= '0;  result_q <= '0;  gap_q     <= '0;
      sclk_q  <= 1'b0;     cs_n_q   <= 1'b1; mosi_q  <= 1'b0; busy_q    <= 1'b0;
      ready_q <= 1'b0;     rv_q     <= 1'b0; done_q  <= 1'b0;
    end else begin
      state_q <= state_d;  cmd_q    <= cmd_d;    shift_q  <= shift_d;  bit_cnt_q <= bit_cnt_d;
      edge_q  <= edge_d;   res_sh_q <= res_sh_d; result_q <= result_d; gap_q     <= gap_d;
      sclk_q  <= sclk_d;   cs_n_q   <= cs_n_d;   mosi_q   <= mosi_d;   busy_q    <= busy_d;
      ready_q <= ready_d;  rv_q     <= rv_d;     done_q   <= done_d;
    end
  end

  assign o_SPI_Clk      = sclk_q;
  assign o_SPI_CS_n     = cs_n_q;
  assign o_SPI_MOSI     = mosi_q;
  assign o_busy         = busy_q;
  assign o_tx_ready     = ready_q;
  assign o_result       = result_q;
  assign o_result_valid = rv_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_spi_cnn_master.sv
// Directed bench for spi_cnn_master with a bit-level SPI slave/MISO model.
module tb_spi_cnn_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_GAP  = 2;
  localparam int LIMIT = 3000;

  logic       i_CLOCK = 1'b0;
  logic       i_RESET = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_cmd = 2'b00;
  logic [7:0] i_tx_data;
  logic       i_tx_valid = 1'b0;
  logic       i_SPI_MISO = 1'b0;
  logic       o_tx_ready, o_SPI_Clk, o_SPI_CS_n, o_SPI_MOSI, o_busy;
  logic [3:0] o_result;
  logic       o_result_valid, o_done;
`ifdef SPI_CNN_MASTER_ABORT_EN
  logic       o_aborted;
`endif

  always #5 i_CLOCK = ~i_CLOCK;

  spi_cnn_master #(
    .CLK_DIV(CLK_DIV), .DATAWIDTH_BUS(8), .N_ROWS(8), .N_WEIGHTS(8), .CS_GAP(CS_GAP)
  ) dut (
    .i_CLOCK(i_CLOCK), .i_RESET(i_RESET), .i_start(i_start), .i_cmd(i_cmd),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_SPI_Clk(o_SPI_Clk), .o_SPI_CS_n(o_SPI_CS_n), .o_SPI_MOSI(o_SPI_MOSI),
    .i_SPI_MISO(i_SPI_MISO),
`ifdef SPI_CNN_MASTER_ABORT_EN
    .i_abort(1'b0), .o_aborted(o_aborted),
`endif
    .o_busy(o_busy), .o_result(o_result), .o_result_valid(o_result_valid), .o_done(o_done)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte source: restarts at index 0 on every start pulse or reset
  logic [7:0] tx_bytes [0:7];
  int byte_idx = 0;
  assign i_tx_data = (byte_idx < 8) ? tx_bytes[byte_idx] : 8'h00;
  always @(posedge i_CLOCK) begin
    if (i_RESET || i_start)          byte_idx <= 0;
    else if (i_tx_valid && o_tx_ready) byte_idx <= byte_idx + 1;
  end

  // Slave model sampled on the falling system edge: MOSI capture, MISO drive, protocol monitors
  logic       rx_bits [0:127];
  logic [3:0] miso_word = 4'h0;
  int rise_cnt = 0, done_cnt = 0, rv_cnt = 0, viol_cnt = 0;
  int rx_n = 0, fall_n = 0, cs_high_run = 0, last_gap = 0;
  logic rv_at_fall = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(negedge i_CLOCK) begin
    if (o_SPI_CS_n !== prev_cs && (prev_sclk || o_SPI_Clk)) viol_cnt++;
    if (o_SPI_Clk !== prev_sclk && (prev_cs || o_SPI_CS_n)) viol_cnt++;
    if (prev_cs && !o_SPI_CS_n) begin
      last_gap = cs_high_run;
      rx_n = 0;
      fall_n = 0;
    end
    cs_high_run = o_SPI_CS_n ? cs_high_run + 1 : 0;
    if (!prev_sclk && o_SPI_Clk) begin
      rise_cnt++;
      if (rx_n < 128) rx_bits[rx_n] = o_SPI_MOSI;
      rx_n++;
    end
    if (prev_sclk && !o_SPI_Clk) begin
      fall_n++;
      i_SPI_MISO = (fall_n >= 3 && fall_n <= 6) ? miso_word[6 - fall_n] : 1'b0;
    end
    if (o_done) done_cnt++;
    if (o_result_valid) begin
      rv_cnt++;
      rv_at_fall = prev_sclk && !o_SPI_Clk && !o_SPI_CS_n;
    end
    prev_sclk = o_SPI_Clk;
    prev_cs   = o_SPI_CS_n;
  end

  function automatic logic [7:0] rx_byte(input int i);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[7-b] = rx_bits[2 + 8*i + b];
    return v;
  endfunction

  task automatic start_frame(input logic [1:0] c);
    @(posedge i_CLOCK); #1;
    i_cmd = c;
    i_start = 1'b1;
    @(posedge i_CLOCK); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < LIMIT) begin
      @(negedge i_CLOCK);
      if (o_done) break;
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < LIMIT), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (n < LIMIT && o_busy !== 1'b0) begin
      @(negedge i_CLOCK);
      n++;
    end
    check({tag, "_idle_seen"}, 32'(n < LIMIT), 1);
  endtask

  logic [7:0] rows [0:7];
  logic [7:0] wts  [0:7];
  int r0, d0, v0, r1, stall_bad, n;

  initial begin
    rows = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hFF, 8'h00, 8'hA5, 8'h5A};
    wts  = '{8'h3C, 8'hC3, 8'h96, 8'h69, 8'h0F, 8'hF0, 8'h55, 8'hAA};
    tx_bytes = rows;

    // Reset state
    repeat (3) @(posedge i_CLOCK);
    @(negedge i_CLOCK);
    check("rst_cs_n", o_SPI_CS_n, 1);
    check("rst_sclk", o_SPI_Clk, 0);
    check("rst_mosi", o_SPI_MOSI, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_tx_ready, 0);
    check("rst_result", o_result, 0);
    check("rst_rv", o_result_valid, 0);
    check("rst_done", o_done, 0);
    i_RESET = 1'b0;

    // LOAD_IMAGE, valid always high
    i_tx_valid = 1'b1;
    r0 = rise_cnt; d0 = done_cnt;
    start_frame(2'b00);
    wait_done("img");
    wait_idle("img");
    check("img_sclk_periods", rise_cnt - r0, 66);
    check("img_done_count", done_cnt - d0, 1);
    check("img_cmd", {rx_bits[0], rx_bits[1]}, 2'b00);
    for (int i = 0; i < 8; i++) check($sformatf("img_row%0d", i), rx_byte(i), rows[i]);

    // READ_RESULT with 0111 then 1010
    i_tx_valid = 1'b0;
    miso_word = 4'b0111;
    r0 = rise_cnt; v0 = rv_cnt;
    start_frame(2'b11);
    wait_done("rd7");
    check("rd7_result", o_result, 4'h7);
    check("rd7_rv_count", rv_cnt - v0, 1);
    check("rd7_rv_at_hold_entry", rv_at_fall, 1);
    check("rd7_sclk_periods", rise_cnt - r0, 7);
    check("rd7_mosi_bits", {rx_bits[0], rx_bits[1], rx_bits[2], rx_bits[3], rx_bits[4], rx_bits[5], rx_bits[6]}, 7'b1100000);
    wait_idle("rd7");

    miso_word = 4'hA;
    r0 = rise_cnt; v0 = rv_cnt;
    start_frame(2'b11);
    wait_done("rdA");
    check("rdA_result", o_result, 4'hA);
    check("rdA_rv_count", rv_cnt - v0, 1);
    check("rdA_rv_at_hold_entry", rv_at_fall, 1);
    check("rdA_sclk_periods", rise_cnt - r0, 7);
    wait_idle("rdA");

    // START_CNN
    r0 = rise_cnt;
    start_frame(2'b10);
    wait_done("start");
    check("start_sclk_periods", rise_cnt - r0, 3);
    check("start_slave_bits", rx_n, 3);
    check("start_cmd", {rx_bits[0], rx_bits[1], rx_bits[2]}, 3'b100);
    wait_idle("start");

    // LOAD_WEIGHTS with a 20-cycle stall before byte 3
    tx_bytes = wts;
    i_tx_valid = 1'b1;
    r0 = rise_cnt;
    start_frame(2'b01);
    n = 0;
    while (n < LIMIT && byte_idx != 3) begin @(negedge i_CLOCK); n++; end
    check("stall_reach_byte3", 32'(n < LIMIT), 1);
    i_tx_valid = 1'b0;
    n = 0;
    while (n < LIMIT && o_tx_ready !== 1'b1) begin @(negedge i_CLOCK); n++; end
    check("stall_ready_seen", 32'(n < LIMIT), 1);
    r1 = rise_cnt;
    stall_bad = 0;
    repeat (20) begin
      @(negedge i_CLOCK);
      if (o_SPI_Clk !== 1'b0 || o_SPI_CS_n !== 1'b0 || o_tx_ready !== 1'b1) stall_bad++;
    end
    check("stall_lines_held", stall_bad, 0);
    check("stall_no_edges", rise_cnt - r1, 0);
    i_tx_valid = 1'b1;
    wait_done("wts");
    check("wts_sclk_periods", rise_cnt - r0, 66);
    check("wts_cmd", {rx_bits[0], rx_bits[1]}, 2'b01);
    for (int i = 0; i < 8; i++) check($sformatf("wts_byte%0d", i), rx_byte(i), wts[i]);
    wait_idle("wts");

    // Reset in the middle of byte 4
    r0 = rise_cnt; d0 = done_cnt;
    start_frame(2'b01);
    n = 0;
    while (n < LIMIT && (rise_cnt - r0 < 30 || o_SPI_Clk !== 1'b0)) begin @(negedge i_CLOCK); n++; end
    check("midrst_reach_byte4", 32'(n < LIMIT), 1);
    i_RESET = 1'b1;
    @(negedge i_CLOCK);
    check("midrst_cs_n", o_SPI_CS_n, 1);
    check("midrst_sclk", o_SPI_Clk, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    i_RESET = 1'b0;
    i_tx_valid = 1'b0;
    repeat (5) @(negedge i_CLOCK);
    check("midrst_no_done", done_cnt - d0, 0);
    r0 = rise_cnt;
    start_frame(2'b10);
    wait_done("after_rst");
    check("after_rst_periods", rise_cnt - r0, 3);
    check("after_rst_bits", {rx_bits[0], rx_bits[1], rx_bits[2]}, 3'b100);
    wait_idle("after_rst");

    // Starts while busy and during GAP are ignored; back-to-back spacing
    r0 = rise_cnt; d0 = done_cnt;
    start_frame(2'b10);
    repeat (4) @(negedge i_CLOCK);
    i_cmd = 2'b00; i_start = 1'b1;
    @(negedge i_CLOCK);
    i_start = 1'b0;
    wait_done("b2b_a");
    i_cmd = 2'b00; i_start = 1'b1;
    @(negedge i_CLOCK);
    i_start = 1'b0;
    wait_idle("b2b_a");
    check("b2b_single_frame_periods", rise_cnt - r0, 3);
    check("b2b_single_done", done_cnt - d0, 1);
    start_frame(2'b10);
    wait_done("b2b_b");
    check("b2b_cs_gap_ok", 32'(last_gap >= CS_GAP), 1);
    check("b2b_total_periods", rise_cnt - r0, 6);
    wait_idle("b2b_b");

    check("protocol_violations", viol_cnt, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
